// File: rtl/cache_pkg.sv
// Cache-bus types: coherence controller states and the RAM handshake encoding.
package cache_pkg;
  localparam int CPUS = 2;

  typedef enum logic [3:0] {
    IDLE, WB1, WB2, SNOOP, RAMRD1, RAMRD2, C2C1, C2C2, IFETCH
  } ccstate_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide data types shared by the cache and bus blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-requester grant with round-robin tie-break; the last-grant bit moves
// only when the owning transaction reports completion.
module bus_rr_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_id,
  output logic       o_valid,
  output logic       o_gnt
);
  logic r_last;

  always_comb begin
    o_valid = |i_req;
    o_gnt   = (&i_req) ? ~r_last : i_req[1];
  end

  // Reset to 1 so core 0 takes the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_last <= 1'b1;
    else if (i_done) r_last <= i_done_id;
  end
endmodule

// File: rtl/coherence_ctrl.sv
// Bus-side coherence/memory controller: two caches onto one RAM port.
// Define COHERENCE_CTRL_SNOOP_EN to enable peer snooping and cache-to-cache supply.
module coherence_ctrl
  import cache_pkg::*;
  import cpu_types_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  input  logic  [CPUS-1:0]    iREN,
  input  word_t [CPUS-1:0]    iaddr,
  output logic  [CPUS-1:0]    iwait,
  output word_t [CPUS-1:0]    iload,
  input  logic  [CPUS-1:0]    dREN,
  input  logic  [CPUS-1:0]    dWEN,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  input  logic  [CPUS-1:0]    cctrans,
  input  logic  [CPUS-1:0]    ccwrite,
  output logic  [CPUS-1:0]    dwait,
  output word_t [CPUS-1:0]    dload,
  output logic  [CPUS-1:0]    ccwait,
  output logic  [CPUS-1:0]    ccinv,
  output word_t [CPUS-1:0]    ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  logic  [1:0]         ramstate
);
  ccstate_t        r_state;
  logic            r_g;
  logic            w_p;
  logic            w_acc;
  logic            w_done;
  logic            w_valid;
  logic            w_gnt;
  logic [CPUS-1:0] w_req;
  logic [CPUS-1:0] w_rdc;

`ifdef COHERENCE_CTRL_SNOOP_EN
  logic r_inv;
  logic r_coh;
  assign w_rdc = dREN & cctrans;
`else
  logic w_unused;
  assign w_rdc    = '0;
  assign w_unused = ^{cctrans, ccwrite};
`endif

  assign w_p   = ~r_g;
  // ERROR never completes a beat, so it behaves exactly like BUSY.
  assign w_acc = (ramstate == ACCESS);
  assign w_done = w_acc && (r_state == WB2 || r_state == RAMRD2 ||
                            r_state == C2C2 || r_state == IFETCH);

  always_comb begin
    w_req = iREN;
    if (|dWEN)       w_req = dWEN;
    else if (|w_rdc) w_req = w_rdc;
    else if (|dREN)  w_req = dREN;
  end

  bus_rr_arbiter u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_req     (w_req),
    .i_done    (w_done),
    .i_done_id (r_g),
    .o_valid   (w_valid),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
`ifdef COHERENCE_CTRL_SNOOP_EN
      r_inv   <= 1'b0;
      r_coh   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_g <= w_gnt;
`ifdef COHERENCE_CTRL_SNOOP_EN
          r_inv <= 1'b0;
          r_coh <= 1'b0;
`endif
          if (dWEN[w_gnt])        r_state <= WB1;
          else if (dREN[w_gnt]) begin
`ifdef COHERENCE_CTRL_SNOOP_EN
            if (cctrans[w_gnt])   r_state <= SNOOP;
            else
`endif
                                  r_state <= RAMRD1;
          end
          else                    r_state <= IFETCH;
        end
        WB1:    if (w_acc) r_state <= WB2;
        WB2:    if (w_acc) r_state <= IDLE;
        RAMRD1: if (w_acc) r_state <= RAMRD2;
        RAMRD2: if (w_acc) r_state <= IDLE;
        IFETCH: if (w_acc) r_state <= IDLE;
`ifdef COHERENCE_CTRL_SNOOP_EN
        SNOOP: begin
          r_coh   <= 1'b1;
          r_inv   <= ccwrite[r_g];
          r_state <= ccwrite[w_p] ? C2C1 : RAMRD1;
        end
        C2C1:   if (w_acc) r_state <= C2C2;
        C2C2:   if (w_acc) r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      WB1, WB2: begin
        ramWEN     = 1'b1;
        ramaddr    = daddr[r_g];
        ramstore   = dstore[r_g];
        dwait[r_g] = ~w_acc;
      end
      RAMRD1, RAMRD2: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[r_g];
        dload[r_g] = ramload;
        dwait[r_g] = ~w_acc;
`ifdef COHERENCE_CTRL_SNOOP_EN
        // Keep the peer parked on the snoop until the requester's block lands.
        if (r_coh) begin
          ccwait[w_p]      = 1'b1;
          ccinv[w_p]       = r_inv;
          ccsnoopaddr[w_p] = daddr[r_g];
        end
`endif
      end
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[r_g];
        iload[r_g] = ramload;
        iwait[r_g] = ~w_acc;
      end
`ifdef COHERENCE_CTRL_SNOOP_EN
      SNOOP: begin
        ccwait[w_p]      = 1'b1;
        ccinv[w_p]       = ccwrite[r_g];
        ccsnoopaddr[w_p] = daddr[r_g];
      end
      C2C1, C2C2: begin
        dload[r_g]       = dstore[w_p];
        ramWEN           = 1'b1;
        ramaddr          = daddr[r_g];
        ramstore         = dstore[w_p];
        dwait[r_g]       = ~w_acc;
        dwait[w_p]       = ~w_acc;
        ccwait[w_p]      = 1'b1;
        ccinv[w_p]       = r_inv;
        ccsnoopaddr[w_p] = daddr[r_g];
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed bench for coherence_ctrl with a latency-programmable RAM model.
module tb_coherence_ctrl;
  import cache_pkg::*;
  import cpu_types_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic  [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  word_t [1:0]  iaddr, daddr, dstore;
  logic  [1:0]  iwait, dwait, ccwait, ccinv;
  word_t [1:0]  iload, dload, ccsnoopaddr;
  logic         ramREN, ramWEN;
  word_t        ramaddr, ramstore, ramload;
  logic  [1:0]  ramstate;

  int checks = 0;
  int errors = 0;
  int ram_lat = 2;
  bit err_mode = 1'b0;
  int cnt = 0;
  int iw0_lows = 0;
  logic [31:0] mem [256];
  bit          wr_v [256];

  always #5 CLK = ~CLK;

  coherence_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // Unwritten words read back as C0DE0000 | word index.
  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return wr_v[idx] ? mem[idx] : (32'hC0DE0000 | {24'd0, idx});
  endfunction

  assign ramload  = rd(ramaddr);
  assign ramstate = !(ramREN || ramWEN) ? FREE :
                    (cnt == ram_lat - 1) ? ACCESS : (err_mode ? ERROR : BUSY);

  always @(posedge CLK) begin
    if (ramREN || ramWEN) cnt <= (cnt == ram_lat - 1) ? 0 : cnt + 1;
    else                  cnt <= 0;
    if (ramWEN && ramstate == ACCESS) begin
      mem[ramaddr[9:2]]  <= ramstore;
      wr_v[ramaddr[9:2]] <= 1'b1;
    end
  end

  always @(negedge CLK) if (!iwait[0]) iw0_lows <= iw0_lows + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int s);
    case (s)
      0: return !dwait[0];
      1: return !dwait[1];
      2: return !iwait[0];
      3: return !iwait[1];
      4: return ccwait[0];
      5: return ccwait[1];
      6: return !(&iwait);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wt(input int sel, output int n);
    bit hit = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      n++;
      if (cond(sel)) begin hit = 1'b1; break; end
    end
    chk($sformatf("wait%0d", sel), 32'(hit), 1);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n, who, base;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;

    repeat (2) @(negedge CLK);
    chk("rst_iwait",  32'(iwait), 3);
    chk("rst_dwait",  32'(dwait), 3);
    chk("rst_ren",    32'(ramREN), 0);
    chk("rst_wen",    32'(ramWEN), 0);
    chk("rst_addr",   ramaddr, 0);
    chk("rst_ccwait", 32'(ccwait), 0);
    chk("rst_dload",  dload[0], 0);
    tick; nRST = 1'b1;

    // Writeback of a 2-word block from core 0.
    tick; dWEN[0] = 1'b1; daddr[0] = 'h100; dstore[0] = 'hAAAA;
    wt(0, n);
    chk("wb_lat", 32'(n), 3);
    chk("wb1_wen", 32'(ramWEN), 1);
    chk("wb1_addr", ramaddr, 'h100);
    chk("wb1_data", ramstore, 'hAAAA);
    chk("wb1_dw1", 32'(dwait[1]), 1);
    tick; daddr[0] = 'h104; dstore[0] = 'hBBBB;
    wt(0, n);
    chk("wb2_lat", 32'(n), 2);
    chk("wb2_addr", ramaddr, 'h104);
    chk("wb2_data", ramstore, 'hBBBB);
    tick; dWEN[0] = 1'b0;
    @(negedge CLK);
    chk("wb_idle_dw", 32'(dwait), 3);
    chk("wb_idle_wen", 32'(ramWEN), 0);
    chk("wb_mem0", rd('h100), 'hAAAA);
    chk("wb_mem1", rd('h104), 'hBBBB);

    // Coherent read by core 0; peer does not hold the block.
    tick; dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 'h200;
`ifdef COHERENCE_CTRL_SNOOP_EN
    wt(5, n);
    chk("snp_lat", 32'(n), 2);
    chk("snp_addr", ccsnoopaddr[1], 'h200);
    chk("snp_inv", 32'(ccinv[1]), 0);
    chk("snp_ren", 32'(ramREN), 0);
    chk("snp_dw", 32'(dwait[0]), 1);
    wt(0, n);
    chk("rd_lat", 32'(n), 2);
`else
    wt(0, n);
    chk("rd_lat", 32'(n), 3);
    chk("rd_ccw", 32'(ccwait), 0);
`endif
    chk("rd1_data", dload[0], 32'hC0DE0080);
    chk("rd1_addr", ramaddr, 'h200);
    chk("rd1_ren", 32'(ramREN), 1);
    tick; daddr[0] = 'h204;
    wt(0, n);
    chk("rd2_data", dload[0], 32'hC0DE0081);
    tick; dREN[0] = 1'b0; cctrans[0] = 1'b0;

    // Read-exclusive by core 1.
    tick; dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 'h300;
`ifdef COHERENCE_CTRL_SNOOP_EN
    ccwrite[0] = 1'b1; dstore[0] = 'h11;
    wt(4, n);
    chk("x_snp_addr", ccsnoopaddr[0], 'h300);
    chk("x_snp_inv", 32'(ccinv[0]), 1);
    wt(1, n);
    chk("c2c_lat", 32'(n), 2);
    chk("c2c1_dload", dload[1], 'h11);
    chk("c2c1_dw0", 32'(dwait[0]), 0);
    chk("c2c1_wen", 32'(ramWEN), 1);
    chk("c2c1_store", ramstore, 'h11);
    chk("c2c1_addr", ramaddr, 'h300);
    tick; daddr[1] = 'h304; dstore[0] = 'h22;
    wt(1, n);
    chk("c2c2_dload", dload[1], 'h22);
    chk("c2c2_dw0", 32'(dwait[0]), 0);
    chk("c2c2_ccw", 32'(ccwait[0]), 1);
    chk("c2c2_inv", 32'(ccinv[0]), 1);
    tick; dREN[1] = 1'b0; cctrans[1] = 1'b0; ccwrite = '0;
    @(negedge CLK);
    chk("c2c_idle_ccw", 32'(ccwait), 0);
    chk("c2c_idle_inv", 32'(ccinv), 0);
    chk("c2c_mem0", rd('h300), 'h11);
    chk("c2c_mem1", rd('h304), 'h22);
`else
    wt(1, n);
    chk("x_lat", 32'(n), 3);
    chk("x1_dload", dload[1], 32'hC0DE00C0);
    chk("x1_inv", 32'(ccinv), 0);
    tick; daddr[1] = 'h304;
    wt(1, n);
    chk("x2_dload", dload[1], 32'hC0DE00C1);
    tick; dREN[1] = 1'b0; cctrans[1] = 1'b0; ccwrite = '0;
`endif

    // Both cores fetch continuously: grants alternate starting with core 0.
    tick; iREN = 2'b11; iaddr[0] = 'h10; iaddr[1] = 'h20;
    for (int k = 0; k < 4; k++) begin
      wt(6, n);
      who = iwait[0] ? 1 : 0;
      chk($sformatf("if_order%0d", k), 32'(who), 32'(k % 2));
      chk($sformatf("if_one%0d", k), 32'(iwait[0] ^ iwait[1]), 1);
      chk($sformatf("if_data%0d", k), iload[who], who ? 32'hC0DE0008 : 32'hC0DE0004);
      tick;
    end
    iREN = '0;

    // Same-core data + fetch, with ERROR in place of BUSY on the RAM.
    ram_lat = 3; err_mode = 1'b1; base = iw0_lows;
    tick; dREN[0] = 1'b1; daddr[0] = 'h40; iREN[0] = 1'b1; iaddr[0] = 'h44;
    wt(0, n);
    chk("err_lat", 32'(n), 4);
    chk("nc_ccw", 32'(ccwait), 0);
    chk("nc1_data", dload[0], 32'hC0DE0010);
    tick; daddr[0] = 'h48;
    wt(0, n);
    chk("nc2_lat", 32'(n), 3);
    chk("nc2_data", dload[0], 32'hC0DE0012);
    tick; dREN[0] = 1'b0;
    chk("iw_hold", 32'(iw0_lows - base), 0);
    wt(2, n);
    chk("if_after", iload[0], 32'hC0DE0011);
    tick; iREN = '0; err_mode = 1'b0; ram_lat = 2;

    // Asynchronous reset in the middle of RAMRD1.
    ram_lat = 4;
    tick; dREN[1] = 1'b1; daddr[1] = 'h80;
    repeat (2) @(negedge CLK);
    chk("mid_ren", 32'(ramREN), 1);
    #2 nRST = 1'b0;
    #1;
    chk("ar_dwait", 32'(dwait), 3);
    chk("ar_iwait", 32'(iwait), 3);
    chk("ar_ren", 32'(ramREN), 0);
    chk("ar_addr", ramaddr, 0);
    chk("ar_dload", dload[1], 0);
    dREN = '0; ram_lat = 2;
    tick; tick; nRST = 1'b1;
    tick; dREN[1] = 1'b1; daddr[1] = 'h80;
    wt(1, n);
    chk("post_lat", 32'(n), 3);
    chk("post1_data", dload[1], 32'hC0DE0020);
    tick; daddr[1] = 'h84;
    wt(1, n);
    chk("post2_data", dload[1], 32'hC0DE0021);
    tick; dREN = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
